// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/NAND/OR/NOR/NOT/XOR/XNOR) among NREQ requesters.
// Optional LU_ILLEGAL_OP_ERR_EN adds rsp_err, flagging the reserved opcode 7.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy
`ifdef LU_ILLEGAL_OP_ERR_EN
  ,
  output logic                  rsp_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   last_reg;
  logic [IDW-1:0]   id_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [2:0]       op_reg;
  logic             rsp_valid_reg;
  logic [IDW-1:0]   rsp_id_reg;
  logic [WIDTH-1:0] rsp_data_reg;

  logic [WIDTH-1:0] a_arr  [NREQ];
  logic [WIDTH-1:0] b_arr  [NREQ];
  logic [2:0]       op_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
      assign op_arr[gi] = req_op[gi*3 +: 3];
    end
  endgenerate

  function automatic logic [WIDTH-1:0] lu_func(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return ~a;
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  // Scan starts one past the last winner so every requester gets a turn.
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  always_comb begin
    int idx;
    logic [IDW-1:0] cand;
    idx         = 0;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_reg) + k) % NREQ;
      cand = IDW'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          state_next           = EXEC;
        end
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LU_ILLEGAL_OP_ERR_EN
  logic err_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      last_reg      <= IDW'(NREQ - 1);
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_data_reg  <= '0;
`ifdef LU_ILLEGAL_OP_ERR_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            a_reg    <= a_arr[grant_idx];
            b_reg    <= b_arr[grant_idx];
            op_reg   <= op_arr[grant_idx];
            id_reg   <= grant_idx;
            last_reg <= grant_idx;
          end
        end
        EXEC: begin
          rsp_data_reg  <= lu_func(op_reg, a_reg, b_reg);
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
`ifdef LU_ILLEGAL_OP_ERR_EN
          err_reg       <= (op_reg == 3'd7);
`endif
        end
        RESP: begin
          if (rsp_ready) rsp_valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_data  = rsp_data_reg;
  assign busy      = (state_reg != IDLE);
`ifdef LU_ILLEGAL_OP_ERR_EN
  assign rsp_err   = err_reg;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: vector table plus scoreboard and multi-cycle sequences.
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0]     req_op;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
`ifdef LU_ILLEGAL_OP_ERR_EN
  logic                  rsp_err;
`endif

  logic [WIDTH-1:0] drv_a  [NREQ];
  logic [WIDTH-1:0] drv_b  [NREQ];
  logic [2:0]       drv_op [NREQ];
  int issued   [NREQ];
  int accepted [NREQ];

  always_comb begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]             = (issued[i] != accepted[i]);
      req_a[i*WIDTH +: WIDTH]  = drv_a[i];
      req_b[i*WIDTH +: WIDTH]  = drv_b[i];
      req_op[i*3 +: 3]         = drv_op[i];
    end
  end

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef LU_ILLEGAL_OP_ERR_EN
    .rsp_err   (rsp_err),
`endif
    .busy      (busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return ~(a & b);
      3'd2:    return a | b;
      3'd3:    return ~(a | b);
      3'd4:    return ~a;
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0, accepts = 0, rsp_total = 0, dropped = 0;
  int grant_log[$];
  int grant_cyc[$];
  logic [NREQ-1:0]  acc_mask = '0;
  logic             hold_prev = 1'b0;
  logic [IDW-1:0]   held_id;
  logic [WIDTH-1:0] held_data;
  logic [IDW-1:0]   last_id;
  logic [WIDTH-1:0] last_data;
  logic             last_err;

  // Scoreboard: push expected on each handshake, pop on each consumed response.
  always @(negedge clk) begin
    exp_t e, got;
    cyc++;
    if (rst) begin
      dropped += exp_q.size();
      exp_q.delete();
      acc_mask  = '0;
      hold_prev = 1'b0;
    end else begin
      acc_mask = req_valid & req_ready;
      if (req_ready != '0) begin
        chk("ready_onehot", $countones(req_ready), 1);
        chk("ready_only_idle", busy, 0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i]) begin
          e.id   = IDW'(i);
          e.data = model(drv_op[i], drv_a[i], drv_b[i]);
          e.err  = (drv_op[i] == 3'd7);
          exp_q.push_back(e);
          grant_log.push_back(i);
          grant_cyc.push_back(cyc);
          accepts++;
        end
      end
      if (hold_prev) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_id", rsp_id, held_id);
        chk("hold_data", rsp_data, held_data);
      end
      if (rsp_valid && rsp_ready) begin
        $display("[TB] rsp id=%0d data=%02h", rsp_id, rsp_data);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rsp_unexpected: got response id=%0d data=%02h, expected none", rsp_id, rsp_data);
        end else begin
          got = exp_q.pop_front();
          chk("sb_id", rsp_id, got.id);
          chk("sb_data", rsp_data, got.data);
`ifdef LU_ILLEGAL_OP_ERR_EN
          chk("sb_err", rsp_err, got.err);
`endif
        end
        last_id   = rsp_id;
        last_data = rsp_data;
`ifdef LU_ILLEGAL_OP_ERR_EN
        last_err  = rsp_err;
`else
        last_err  = 1'b0;
`endif
        rsp_total++;
      end
      hold_prev = rsp_valid && !rsp_ready;
      held_id   = rsp_id;
      held_data = rsp_data;
    end
  end

  // A requester drops valid right after its handshake edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc_mask[i]) accepted[i] = accepted[i] + 1;
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    sync();
    rst = 1'b1;
    sync();
    sync();
    for (int i = 0; i < NREQ; i++) issued[i] = accepted[i];
    rst = 1'b0;
  endtask

  task automatic set_req(input int id, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int n);
    drv_op[id] = op;
    drv_a[id]  = a;
    drv_b[id]  = b;
    issued[id] = issued[id] + n;
  endtask

  task automatic wait_rsp(input int target, input string name);
    for (int k = 0; k < 60 && rsp_total < target; k++) @(negedge clk);
    chk(name, rsp_total, target);
  endtask

  typedef struct {
    int               id;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t, gbase;
    int rr_exp[5];
    vecs[0]  = '{0, 3'd0, 8'hA5, 8'h0F, 8'h05};
    vecs[1]  = '{0, 3'd1, 8'hA5, 8'h0F, 8'hFA};
    vecs[2]  = '{0, 3'd2, 8'hA5, 8'h0F, 8'hAF};
    vecs[3]  = '{0, 3'd3, 8'hA5, 8'h0F, 8'h50};
    vecs[4]  = '{0, 3'd4, 8'hA5, 8'h0F, 8'h5A};
    vecs[5]  = '{0, 3'd5, 8'hA5, 8'h0F, 8'hAA};
    vecs[6]  = '{0, 3'd6, 8'hA5, 8'h0F, 8'h55};
    vecs[7]  = '{2, 3'd5, 8'hF0, 8'h3C, 8'hCC};
    vecs[8]  = '{1, 3'd7, 8'hFF, 8'hFF, 8'h00};
    vecs[9]  = '{1, 3'd0, 8'hF0, 8'h3C, 8'h30};
    vecs[10] = '{3, 3'd2, 8'h12, 8'h40, 8'h52};
    vecs[11] = '{3, 3'd3, 8'h00, 8'h00, 8'hFF};
    rr_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin
      drv_a[i] = '0; drv_b[i] = '0; drv_op[i] = '0;
    end

    // Reset values
    apply_reset();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);

    // Single request timing on requester 2
    sync();
    set_req(2, 3'd5, 8'hF0, 8'h3C, 1);
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0100);
    chk("t1_busy_idle", busy, 0);
    @(negedge clk);
    chk("t1_ready_exec", req_ready, 0);
    chk("t1_busy_exec", busy, 1);
    chk("t1_valid_exec", rsp_valid, 0);
    @(negedge clk);
    chk("t1_valid", rsp_valid, 1);
    chk("t1_id", rsp_id, 2);
    chk("t1_data", rsp_data, 8'hCC);
    chk("t1_busy_resp", busy, 1);
    @(negedge clk);
    chk("t1_valid_drop", rsp_valid, 0);
    chk("t1_busy_done", busy, 0);

    // Vector table
    for (int v = 0; v < 12; v++) begin
      t = rsp_total + 1;
      sync();
      set_req(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b, 1);
      wait_rsp(t, "vec_timeout");
      chk("vec_data", last_data, vecs[v].exp);
      chk("vec_id", last_id, vecs[v].id);
`ifdef LU_ILLEGAL_OP_ERR_EN
      chk("vec_err", last_err, (vecs[v].op == 3'd7));
`endif
    end

    // Round robin with all requesters valid
    apply_reset();
    gbase = grant_log.size();
    base  = rsp_total;
    sync();
    set_req(0, 3'd0, 8'hFF, 8'h0F, 2);
    for (int i = 1; i < NREQ; i++) set_req(i, 3'd0, 8'hFF, 8'h0F, 1);
    wait_rsp(base + 5, "rr_timeout");
    chk("rr_grants", grant_log.size(), gbase + 5);
    if (grant_log.size() >= gbase + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_order", grant_log[gbase+k], rr_exp[k]);
        if (k > 0) chk("rr_spacing", grant_cyc[gbase+k] - grant_cyc[gbase+k-1], 3);
      end
    end

    // Response backpressure with another request pending
    apply_reset();
    rsp_ready = 1'b0;
    base = rsp_total;
    sync();
    set_req(0, 3'd2, 8'h30, 8'h03, 1);
    set_req(1, 3'd5, 8'h0F, 8'hFF, 1);
    for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
    chk("bp_valid_seen", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 0);
      chk("bp_data", rsp_data, 8'h33);
      chk("bp_ready", req_ready, 0);
    end
    sync();
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0010);
    wait_rsp(base + 2, "bp_timeout");

    // Reset during EXEC discards the op and rewinds the pointer
    apply_reset();
    sync();
    set_req(2, 3'd2, 8'h11, 8'h22, 1);
    @(negedge clk);
    chk("re_ready", req_ready, 4'b0100);
    sync();
    rst = 1'b1;
    @(negedge clk);
    chk("re_busy_exec", busy, 1);
    sync();
    rst = 1'b0;
    base = rsp_total;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("re_busy", busy, 0);
      chk("re_no_rsp", rsp_valid, 0);
    end
    sync();
    set_req(0, 3'd1, 8'hF0, 8'h3C, 1);
    set_req(3, 3'd3, 8'h0F, 8'h00, 1);
    @(negedge clk);
    chk("re_grant0", req_ready, 4'b0001);
    wait_rsp(base + 2, "re_timeout");

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("rsp_count", rsp_total + dropped, accepts);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
